// File: rtl/offnariscv_ace_line_fill.sv
// rtl/offnariscv_ace_line_fill.sv - ACE cache-line fill master (one WRAP read burst per request)
//
// Accepts one line-fill request, issues a single ReadShared/ReadUnique burst on AR,
// gathers LINE_WIDTH/ACE_XDATA_WIDTH R beats critical-word-first, and returns the line.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_*                    request (valid/ready, byte address, unique)
//   resp_*                   assembled line (valid/ready, data, err/shared/dirty flags)
//   ar*                      ACE read address channel (master side)
//   r*, rready               ACE read data channel
//   rack                     read acknowledge, one-cycle pulse after the final beat
module offnariscv_ace_line_fill #(
  parameter int ACE_XDATA_WIDTH  = 64,
  parameter int LINE_WIDTH       = 256,
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int ACE_XID_WIDTH    = 4,
  parameter int ACE_XUSER_WIDTH  = 1,
  parameter logic [ACE_XID_WIDTH-1:0] AR_ID = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ACE_AXADDR_WIDTH-1:0] req_addr,
  input  logic                        req_unique,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [LINE_WIDTH-1:0]       resp_data,
  output logic                        resp_err,
  output logic                        resp_shared,
  output logic                        resp_dirty,
  output logic [ACE_XID_WIDTH-1:0]    arid,
  output logic [ACE_AXADDR_WIDTH-1:0] araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic [3:0]                  arqos,
  output logic [3:0]                  arregion,
  output logic [ACE_XUSER_WIDTH-1:0]  aruser,
  output logic [3:0]                  arsnoop,
  output logic [1:0]                  ardomain,
  output logic [1:0]                  arbar,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ACE_XID_WIDTH-1:0]    rid,
  input  logic [ACE_XDATA_WIDTH-1:0]  rdata,
  input  logic [3:0]                  rresp,
  input  logic                        rlast,
  input  logic [ACE_XUSER_WIDTH-1:0]  ruser,
  input  logic                        rvalid,
  output logic                        rready,
  output logic                        rack
);

  localparam int BEATS = LINE_WIDTH / ACE_XDATA_WIDTH;
  localparam int OFF_W = $clog2(ACE_XDATA_WIDTH / 8);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_e;

  state_e                      state_q, state_d;
  logic [ACE_AXADDR_WIDTH-1:0] addr_q, addr_d;
  logic                        unique_q, unique_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]       line_q, line_d;
  logic                        err_q, err_d;
  logic                        shared_q, shared_d;
  logic                        dirty_q, dirty_d;
  logic                        req_ready_q, req_ready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic                        rack_q, rack_d;
  logic                        beat_last;

  // Completion is decided by the beat counter; rlast only feeds the error flag.
  assign beat_last = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    unique_d     = unique_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    err_d        = err_q;
    shared_d     = shared_q;
    dirty_d      = dirty_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    rack_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[ACE_AXADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          unique_d    = req_unique;
          // Critical beat = beat position of the address within the line.
          idx_d       = (BEATS > 1) ? req_addr[OFF_W +: IDX_W] : '0;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          arvalid_d   = 1'b1;
          state_d     = S_AR;
        end
      end
      S_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (rvalid && rready_q) begin
          line_d[idx_q*ACE_XDATA_WIDTH +: ACE_XDATA_WIDTH] = rdata;
          if (BEATS > 1) idx_d = idx_q + 1'b1;  // power-of-two BEATS: natural wrap
          cnt_d    = cnt_q + 1'b1;
          err_d    = err_q | rresp[1] | (rid != AR_ID) | (rlast != beat_last);
          shared_d = shared_q | rresp[3];
          dirty_d  = dirty_q | rresp[2];
          if (beat_last) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            rack_d       = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          err_d        = 1'b0;
          shared_d     = 1'b0;
          dirty_d      = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      unique_q     <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      shared_q     <= 1'b0;
      dirty_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      rack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      unique_q     <= unique_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      err_q        <= err_d;
      shared_q     <= shared_d;
      dirty_q      <= dirty_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      rack_q       <= rack_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = line_q;
  assign resp_err    = err_q;
  assign resp_shared = shared_q;
  assign resp_dirty  = dirty_q;
  assign rready      = rready_q;
  assign rack        = rack_q;

  assign arvalid  = arvalid_q;
  assign arid     = AR_ID;
  assign araddr   = addr_q;
  assign arlen    = 8'(BEATS - 1);
  assign arsize   = 3'(OFF_W);
  assign arburst  = (BEATS > 1) ? 2'b10 : 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'b1111;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;
  assign aruser   = '0;
  assign arsnoop  = unique_q ? 4'b0111 : 4'b0001;
  assign ardomain = 2'b01;
  assign arbar    = 2'b00;

  logic unused_inputs;
  assign unused_inputs = ^{ruser, rresp[0], req_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_offnariscv_ace_line_fill.sv
// tb/tb_offnariscv_ace_line_fill.sv - self-checking bench for offnariscv_ace_line_fill
//
// u_a: 64-bit beats, 256-bit line (4-beat WRAP). u_b: 256-bit beats (single INCR beat).
module tb_offnariscv_ace_line_fill;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_unique = 1'b0;
  logic         resp_ready = 1'b0;
  logic         a_arready = 1'b0, b_arready = 1'b0;
  logic         a_rvalid = 1'b0, b_rvalid = 1'b0;
  logic [3:0]   rid = '0;
  logic [255:0] rdata = '0;
  logic [3:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         ruser = 1'b0;

  logic         a_req_ready, a_resp_valid, a_resp_err, a_resp_shared, a_resp_dirty;
  logic [255:0] a_resp_data;
  logic [3:0]   a_arid, a_arcache, a_arqos, a_arregion, a_arsnoop;
  logic [31:0]  a_araddr;
  logic [7:0]   a_arlen;
  logic [2:0]   a_arsize, a_arprot;
  logic [1:0]   a_arburst, a_ardomain, a_arbar;
  logic         a_arlock, a_aruser, a_arvalid, a_rready, a_rack;

  logic         b_req_ready, b_resp_valid, b_resp_err, b_resp_shared, b_resp_dirty;
  logic [255:0] b_resp_data;
  logic [3:0]   b_arid, b_arcache, b_arqos, b_arregion, b_arsnoop;
  logic [31:0]  b_araddr;
  logic [7:0]   b_arlen;
  logic [2:0]   b_arsize, b_arprot;
  logic [1:0]   b_arburst, b_ardomain, b_arbar;
  logic         b_arlock, b_aruser, b_arvalid, b_rready, b_rack;

  int checks = 0;
  int errors = 0;

  logic [63:0] bt_data [4];
  logic [3:0]  bt_resp [4];
  logic        bt_ridbad [4];
  logic        bt_last [4];

  always #5 clk = ~clk;

  offnariscv_ace_line_fill #(.ACE_XDATA_WIDTH(64), .LINE_WIDTH(256)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(req_addr), .req_unique(req_unique),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_data(a_resp_data),
    .resp_err(a_resp_err), .resp_shared(a_resp_shared), .resp_dirty(a_resp_dirty),
    .arid(a_arid), .araddr(a_araddr), .arlen(a_arlen), .arsize(a_arsize), .arburst(a_arburst),
    .arlock(a_arlock), .arcache(a_arcache), .arprot(a_arprot), .arqos(a_arqos),
    .arregion(a_arregion), .aruser(a_aruser), .arsnoop(a_arsnoop), .ardomain(a_ardomain),
    .arbar(a_arbar), .arvalid(a_arvalid), .arready(a_arready),
    .rid(rid), .rdata(rdata[63:0]), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(a_rvalid), .rready(a_rready), .rack(a_rack)
  );

  offnariscv_ace_line_fill #(.ACE_XDATA_WIDTH(256), .LINE_WIDTH(256)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(req_addr), .req_unique(req_unique),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_data(b_resp_data),
    .resp_err(b_resp_err), .resp_shared(b_resp_shared), .resp_dirty(b_resp_dirty),
    .arid(b_arid), .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
    .arlock(b_arlock), .arcache(b_arcache), .arprot(b_arprot), .arqos(b_arqos),
    .arregion(b_arregion), .aruser(b_aruser), .arsnoop(b_arsnoop), .ardomain(b_ardomain),
    .arbar(b_arbar), .arvalid(b_arvalid), .arready(b_arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(b_rvalid), .rready(b_rready), .rack(b_rack)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_req_ready"}, a_req_ready, 1);
    chk({tag, "_ctrl"}, {a_arvalid, a_rready, a_resp_valid, a_rack}, 0);
    chk({tag, "_flags"}, {a_resp_err, a_resp_shared, a_resp_dirty}, 0);
    chk({tag, "_data"}, a_resp_data, 0);
  endtask

  // Reference model: beat k of the burst belongs to line slot (crit+k) mod 4.
  task automatic run_a(input logic [31:0] addr, input logic uniq, input int ar_delay,
                       input int resp_delay, input int gap_max, input int abort_at);
    logic [255:0] exp_line;
    logic         e_err, e_sh, e_dy;
    int           crit;
    crit     = int'((addr >> 3) % 4);
    exp_line = '0;
    e_err = 0; e_sh = 0; e_dy = 0;
    for (int k = 0; k < 4; k++) begin
      exp_line[((crit + k) % 4) * 64 +: 64] = bt_data[k];
      e_err |= bt_resp[k][1] | bt_ridbad[k] | (bt_last[k] != (k == 3));
      e_sh  |= bt_resp[k][3];
      e_dy  |= bt_resp[k][2];
    end

    @(negedge clk);
    chk("req_ready_idle", a_req_ready, 1);
    a_req_valid = 1; req_addr = addr; req_unique = uniq;
    @(negedge clk);
    a_req_valid = 0; req_addr = $urandom; req_unique = ~uniq;
    chk("ar_valid", a_arvalid, 1);
    chk("req_ready_busy", a_req_ready, 0);
    chk("araddr", a_araddr, {addr[31:3], 3'b000});
    chk("arlen_size_burst", {a_arlen, a_arsize, a_arburst}, {8'd3, 3'd3, 2'b10});
    chk("arsnoop", a_arsnoop, uniq ? 4'b0111 : 4'b0001);
    chk("ar_attr", {a_arid, a_ardomain, a_arcache, a_arbar}, {4'd0, 2'b01, 4'b1111, 2'b00});
    chk("ar_zero", {a_arlock, a_arprot, a_arqos, a_arregion, a_aruser}, 0);
    for (int i = 0; i < ar_delay; i++) begin
      a_rvalid = 1; rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("ar_hold_valid", a_arvalid, 1);
      chk("ar_hold_addr", a_araddr, {addr[31:3], 3'b000});
      chk("ar_hold_snoop", a_arsnoop, uniq ? 4'b0111 : 4'b0001);
      chk("rready_in_ar", a_rready, 0);
    end
    a_rvalid = 0;
    a_arready = 1;
    @(negedge clk);
    a_arready = 0;
    chk("ar_done", a_arvalid, 0);
    chk("rready_r", a_rready, 1);

    for (int k = 0; k < 4; k++) begin
      int gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        chk("r_gap_ready", {a_rready, a_resp_valid}, 2'b10);
      end
      if (k == abort_at) begin
        #2 rst = 0;
        #1 chk_a_reset("midburst_rst");
        @(negedge clk);
        chk_a_reset("rst_held");
        rst = 1;
        return;
      end
      a_rvalid = 1; rdata = {192'b0, bt_data[k]}; rresp = bt_resp[k];
      rid = bt_ridbad[k] ? 4'h5 : 4'h0; rlast = bt_last[k];
      @(negedge clk);
      a_rvalid = 0; rlast = 0; rresp = 0; rid = 0;
      if (k < 3) chk("no_early_resp", a_resp_valid, 0);
    end

    chk("resp_valid", a_resp_valid, 1);
    chk("rack_pulse", a_rack, 1);
    chk("rready_off", a_rready, 0);
    chk("resp_data", a_resp_data, exp_line);
    chk("resp_flags", {a_resp_err, a_resp_shared, a_resp_dirty}, {e_err, e_sh, e_dy});
    for (int i = 0; i < resp_delay; i++) begin
      @(negedge clk);
      chk("resp_hold", {a_resp_valid, a_rack}, 2'b10);
      chk("resp_hold_data", a_resp_data, exp_line);
      chk("resp_hold_flags", {a_resp_err, a_resp_shared, a_resp_dirty}, {e_err, e_sh, e_dy});
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_done", {a_resp_valid, a_rack, a_req_ready}, 3'b001);
    chk("flags_cleared", {a_resp_err, a_resp_shared, a_resp_dirty}, 0);
  endtask

  task automatic clean_beats();
    for (int k = 0; k < 4; k++) begin
      bt_data[k]   = {$urandom, $urandom};
      bt_resp[k]   = 4'b0000;
      bt_ridbad[k] = 1'b0;
      bt_last[k]   = (k == 3);
    end
  endtask

  initial begin
    logic [255:0] line_b;

    @(negedge clk);
    chk_a_reset("reset_a");
    chk("reset_b", {b_req_ready, b_arvalid, b_rready, b_resp_valid, b_rack, b_resp_err}, 6'b100000);
    chk("reset_b_data", b_resp_data, 0);
    @(negedge clk);
    rst = 1;

    // Critical-word-first: 0x1010 is beat 2 of its line, beats land in slots 2,3,0,1.
    clean_beats();
    run_a(32'h1010, 1'b0, 0, 0, 0, -1);

    // IsShared on the last beat only.
    clean_beats();
    bt_resp[3] = 4'b1000;
    run_a(32'h2008, 1'b0, 1, 0, 1, -1);

    // SLVERR on beat 1 plus rlast early on beat 2; all four beats still consumed.
    clean_beats();
    bt_resp[1] = 4'b0010;
    bt_last[2] = 1'b1;
    bt_last[3] = 1'b0;
    run_a(32'h3000, 1'b1, 0, 1, 0, -1);

    // Slow AR and slow consumer, then a back-to-back request.
    clean_beats();
    bt_resp[0] = 4'b0100;
    run_a(32'h401f, 1'b1, 5, 3, 0, -1);
    clean_beats();
    bt_ridbad[2] = 1'b1;
    run_a(32'h4038, 1'b0, 0, 0, 0, -1);

    // Single-beat configuration.
    @(negedge clk);
    chk("b_req_ready", b_req_ready, 1);
    b_req_valid = 1; req_addr = 32'h40; req_unique = 1;
    @(negedge clk);
    b_req_valid = 0;
    chk("b_arvalid", b_arvalid, 1);
    chk("b_araddr", b_araddr, 32'h40);
    chk("b_ar_fmt", {b_arlen, b_arsize, b_arburst, b_arsnoop}, {8'd0, 3'd5, 2'b01, 4'b0111});
    b_arready = 1;
    @(negedge clk);
    b_arready = 0;
    chk("b_rready", b_rready, 1);
    line_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_rvalid = 1; rdata = line_b; rlast = 1; rresp = 4'b1100;
    @(negedge clk);
    b_rvalid = 0; rlast = 0; rresp = 0;
    chk("b_resp", {b_resp_valid, b_rack, b_rready}, 3'b110);
    chk("b_line", b_resp_data, line_b);
    chk("b_flags", {b_resp_err, b_resp_shared, b_resp_dirty}, 3'b011);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("b_done", {b_resp_valid, b_req_ready}, 2'b01);

    // Asynchronous reset in the middle of the R phase, then a normal fill.
    clean_beats();
    run_a(32'h5010, 1'b0, 0, 0, 0, 2);
    clean_beats();
    bt_resp[2] = 4'b1100;
    run_a(32'h5018, 1'b1, 0, 0, 0, -1);

    // Randomized fills.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 4; k++) begin
        bt_data[k]   = {$urandom, $urandom};
        bt_resp[k]   = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 7) == 0), 1'b0};
        bt_ridbad[k] = ($urandom_range(0, 15) == 0);
        bt_last[k]   = ($urandom_range(0, 15) == 0) ? (k != 3) : (k == 3);
      end
      run_a($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, 3), 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
